led_pwm_driver: RTL

//   Brightness stage downstream of the free-running counter bank. Takes one

---
 rtl/led_pwm_driver.sv | 84 ++++++++
 1 files changed

// File: rtl/led_pwm_driver.sv
// Per-channel PWM dimming of counter blink bits, with duties written through a
// valid/ready port and applied only at PWM period boundaries.
module led_pwm_driver #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned DUTY_W     = 8,
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned RESET_DUTY = 128,
    localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] blink_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DUTY_W-1:0] cfg_duty,
    output logic [NUM_CH-1:0] led_out,
    output logic              period_start
);

    localparam int unsigned PRESC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [DUTY_W-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [NUM_CH-1:0]  led_q, led_d;
    logic               period_start_q, period_start_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic [DUTY_W-1:0]  shadow_q [NUM_CH];
    logic [DUTY_W-1:0]  shadow_d [NUM_CH];
    logic [DUTY_W-1:0]  active_q [NUM_CH];
    logic [DUTY_W-1:0]  active_d [NUM_CH];

    logic tick_c, wrap_c, xfer_c;

    assign tick_c = (presc_q == PRESC_W'(PRESCALE - 1));
    assign wrap_c = tick_c && (pwm_cnt_q == {DUTY_W{1'b1}});
    assign xfer_c = cfg_valid && cfg_ready_q;

    // Next-state: active takes the pre-write shadow, so a colliding write waits a period.
    always_comb begin
        presc_d        = tick_c ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d      = tick_c ? pwm_cnt_q + DUTY_W'(1) : pwm_cnt_q;
        period_start_d = wrap_c;
        cfg_ready_d    = !xfer_c;
        shadow_d       = shadow_q;
        active_d       = active_q;
        if (wrap_c) begin
            active_d = shadow_q;
        end
        if (xfer_c && (32'(cfg_ch) < NUM_CH)) begin
            shadow_d[cfg_ch] = cfg_duty;
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            led_d[i] = blink_in[i] && (pwm_cnt_q < active_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q        <= '0;
            pwm_cnt_q      <= '0;
            led_q          <= '0;
            period_start_q <= 1'b0;
            cfg_ready_q    <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= DUTY_W'(RESET_DUTY);
                active_q[i] <= DUTY_W'(RESET_DUTY);
            end
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            led_q          <= led_d;
            period_start_q <= period_start_d;
            cfg_ready_q    <= cfg_ready_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
        end
    end

    assign led_out      = led_q;
    assign period_start = period_start_q;
    assign cfg_ready    = cfg_ready_q;

endmodule
